// File: rtl/rd_ptr_ctrl.sv
// rd_ptr_ctrl -- read-side pointer controller for an asynchronous FIFO.
//
// Synchronises the Gray write pointer into rd_clk, keeps the binary/Gray
// read pointer, and derives the empty, almost-empty, level and underflow
// flags. FWFT=1 adds a two-state prefetch FSM so the head word is already
// presented (rd_valid) before it is consumed.
//
// Ports
//   rd_clk        in   read-domain clock, rising edge
//   rd_rstn       in   asynchronous active-low reset
//   rd_en         in   read request (standard) / consume acknowledge (FWFT)
//   wr_ptr_gray   in   Gray write pointer from the write clock domain
//   rd_addr       out  memory read address (low bits of binary read pointer)
//   mem_rd_en     out  memory read strobe, combinational
//   rd_ptr_gray   out  registered Gray read pointer, to the write domain
//   empty         out  registered empty flag (FWFT: !rd_valid)
//   almost_empty  out  registered, level <= AE_LEVEL
//   rd_level      out  registered fill level as seen by the read side
//   underflow     out  one-cycle pulse after a rejected read
//   rd_valid      out  FWFT head-word valid; 0 when FWFT=0
module rd_ptr_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 4,
    parameter int FWFT        = 0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow,
    output logic                  rd_valid
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] VALID = 1'b1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] wr_sync;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] level_next;
    logic          ptr_empty;
    logic          ptr_empty_next;
    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          fwft_bonus;

    // Write-pointer synchroniser: only one Gray bit changes per write, so
    // each stage captures either the old or the new pointer, never a mix.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            sync_q <= '0;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray};
            end else begin
                sync_q <= wr_ptr_gray;
            end
        end
    end

    assign wr_sync = sync_q[SYNC_STAGES-1];
    assign wr_bin  = gray2bin(wr_sync);

    // Read strobe and prefetch FSM. The FWFT path keys off the registered
    // pointer-empty flag, which lags wr_sync by a cycle; the writer only
    // moves forward, so the lag can only make the FIFO look emptier.
    always_comb begin
        mem_rd_en  = 1'b0;
        state_next = state;
        if (FWFT != 0) begin
            case (state)
                IDLE: begin
                    if (!ptr_empty) begin
                        mem_rd_en  = 1'b1;
                        state_next = VALID;
                    end
                end
                VALID: begin
                    if (rd_en) begin
                        if (!ptr_empty) begin
                            mem_rd_en = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end else begin
            mem_rd_en = rd_en & ~ptr_empty;
        end
    end

    assign rd_bin_next    = rd_bin + {{ADDR_WIDTH{1'b0}}, mem_rd_en};
    assign ptr_empty_next = (bin2gray(rd_bin_next) == wr_sync);

    // The word parked in the FWFT output register still counts as stored.
    assign fwft_bonus = (FWFT != 0) && (state_next == VALID);
    assign level_next = wr_bin - rd_bin_next + {{ADDR_WIDTH{1'b0}}, fwft_bonus};

    assign empty    = (FWFT != 0) ? (state != VALID) : ptr_empty;
    assign rd_valid = (FWFT != 0) ? (state == VALID) : 1'b0;
    assign rd_addr  = rd_bin[ADDR_WIDTH-1:0];

    // Registered pointer and flag stage
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_bin       <= '0;
            rd_ptr_gray  <= '0;
            ptr_empty    <= 1'b1;
            rd_level     <= '0;
            almost_empty <= 1'b1;
            underflow    <= 1'b0;
            state        <= IDLE;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr_gray  <= bin2gray(rd_bin_next);
            ptr_empty    <= ptr_empty_next;
            rd_level     <= level_next;
            almost_empty <= (level_next <= AE_THR);
            underflow    <= rd_en & empty;
            state        <= state_next;
        end
    end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
module tb_rd_ptr_ctrl;

    localparam int AW = 3;

    logic          rd_clk = 1'b0;
    logic          rstn0, rstn1;
    logic          rd_en0, rd_en1;
    logic [AW:0]   wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic          mre0, mre1;
    logic [AW:0]   gray0, gray1;
    logic          empty0, empty1;
    logic          ae0, ae1;
    logic [AW:0]   lvl0, lvl1;
    logic          uf0, uf1;
    logic          vld0, vld1;

    int n_cmp  = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];

    always #5 rd_clk = ~rd_clk;

    rd_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AE_LEVEL(1), .FWFT(0)) dut0 (
        .rd_clk(rd_clk), .rd_rstn(rstn0), .rd_en(rd_en0), .wr_ptr_gray(wr0),
        .rd_addr(addr0), .mem_rd_en(mre0), .rd_ptr_gray(gray0), .empty(empty0),
        .almost_empty(ae0), .rd_level(lvl0), .underflow(uf0), .rd_valid(vld0)
    );

    rd_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AE_LEVEL(1), .FWFT(1)) dut1 (
        .rd_clk(rd_clk), .rd_rstn(rstn1), .rd_en(rd_en1), .wr_ptr_gray(wr1),
        .rd_addr(addr1), .mem_rd_en(mre1), .rd_ptr_gray(gray1), .empty(empty1),
        .almost_empty(ae1), .rd_level(lvl1), .underflow(uf1), .rd_valid(vld1)
    );

    function automatic logic [AW:0] g(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rd_clk);
            #1;
        end
    endtask

    // Monitors: every memory read strobe must match the next expected address.
    always @(negedge rd_clk) begin
        if (rstn0 === 1'b1 && mre0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rd0_unexpected: read of addr %0d with nothing expected", addr0);
            end else begin
                chk("rd0_addr", int'(addr0), q0.pop_front());
            end
        end
        if (rstn1 === 1'b1 && mre1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rd1_unexpected: read of addr %0d with nothing expected", addr1);
            end else begin
                chk("rd1_addr", int'(addr1), q1.pop_front());
            end
        end
    end

    initial begin
        int r;
        rstn0 = 1'b0; rstn1 = 1'b0;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        wr0 = '0; wr1 = '0;
        #12;
        chk("rst_empty0", empty0, 1);
        chk("rst_ae0", ae0, 1);
        chk("rst_gray0", gray0, 0);
        chk("rst_lvl0", lvl0, 0);
        chk("rst_vld0", vld0, 0);
        chk("rst_empty1", empty1, 1);
        chk("rst_vld1", vld1, 0);
        #2;
        rstn0 = 1'b1; rstn1 = 1'b1;
        tick(1);

        // Standard mode: three words written
        wr0 = 4'b0010;
        tick(3);
        chk("s_empty", empty0, 0);
        chk("s_level3", lvl0, 3);
        chk("s_ae", ae0, 0);
        q0.push_back(0); q0.push_back(1); q0.push_back(2);
        rd_en0 = 1'b1;
        tick(3);
        rd_en0 = 1'b0;
        chk("s_empty_after", empty0, 1);
        chk("s_ae_after", ae0, 1);
        chk("s_gray_after", gray0, 4'b0010);
        chk("s_level_after", lvl0, 0);

        // Underflow: rejected read
        rd_en0 = 1'b1;
        #1;
        chk("u_mre", mre0, 0);
        tick(1);
        rd_en0 = 1'b0;
        chk("u_pulse", uf0, 1);
        chk("u_addr", addr0, 3);
        chk("u_gray", gray0, 4'b0010);
        tick(1);
        chk("u_pulse_end", uf0, 0);

        // Wrap: writer kept 8 ahead while reading 16 words
        r = 3;
        wr0 = g(r + 8);
        tick(3);
        chk("w_level8", lvl0, 8);
        rd_en0 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            q0.push_back(r % 8);
            tick(1);
            r = (r + 1) % 16;
            wr0 = g(r + 8);
            chk("w_gray", gray0, int'(g(r)));
            chk("w_no_empty", empty0, 0);
            if (r == 15) chk("w_gray15", gray0, 4'b1000);
            if (r == 0) begin
                chk("w_gray0", gray0, 4'b0000);
                chk("w_addr0", addr0, 0);
            end
        end
        rd_en0 = 1'b0;

        // FWFT: one word written, prefetched, then consumed
        q1.push_back(0);
        wr1 = 4'b0001;
        tick(3);
        chk("f_mre", mre1, 1);
        chk("f_vld_pre", vld1, 0);
        tick(1);
        chk("f_vld", vld1, 1);
        chk("f_empty", empty1, 0);
        chk("f_mre_off", mre1, 0);
        chk("f_level1", lvl1, 1);
        rd_en1 = 1'b1;
        #1;
        chk("f_mre_pop", mre1, 0);
        tick(1);
        rd_en1 = 1'b0;
        chk("f_vld_done", vld1, 0);
        chk("f_empty_done", empty1, 1);
        chk("f_level0", lvl1, 0);
        chk("f_uf", uf1, 0);

        // Reset mid-stream with level 5 and head word valid
        q1.push_back(1);
        wr1 = g(6);
        tick(4);
        chk("m_vld", vld1, 1);
        chk("m_level5", lvl1, 5);
        #2;
        rstn1 = 1'b0;
        #1;
        chk("m_rst_empty", empty1, 1);
        chk("m_rst_ae", ae1, 1);
        chk("m_rst_gray", gray1, 0);
        chk("m_rst_level", lvl1, 0);
        chk("m_rst_vld", vld1, 0);
        chk("m_rst_uf", uf1, 0);
        chk("m_rst_addr", addr1, 0);
        chk("m_rst_mre", mre1, 0);
        wr1 = '0;
        tick(1);
        rstn1 = 1'b1;
        tick(3);
        chk("m_post_empty", empty1, 1);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_ptr_ctrl.md
RD_PTR_CTRL -- requirements
Module: rd_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width; depth 2^ADDR_WIDTH; pointers ADDR_WIDTH+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flop count of the write-pointer synchroniser; legal 2..4.
REQ-003 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold in words; legal 0..2^ADDR_WIDTH-1.
REQ-004 SHALL have parameter FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-005 rd_clk  in  1  read-domain clock, all state rising-edge.
REQ-006 rd_rstn  in  1  reset, asynchronous, active-low.
REQ-007 rd_en  in  1  read request (standard) / consume acknowledge (FWFT).
REQ-008 wr_ptr_gray  in  ADDR_WIDTH+1  write pointer, Gray-coded, write clock domain.
REQ-009 rd_addr  out  ADDR_WIDTH  memory read address = low bits of binary read pointer.
REQ-010 mem_rd_en  out  1  memory read strobe, combinational.
REQ-011 rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to write domain.
REQ-012 empty  out  1  registered empty flag.
REQ-013 almost_empty  out  1  registered, level <= AE_LEVEL.
REQ-014 rd_level  out  ADDR_WIDTH+1  registered fill level seen by read side.
REQ-015 underflow  out  1  one-cycle pulse on rejected read.
REQ-016 rd_valid  out  1  FWFT data-valid; tied 0 when FWFT=0.

Function
REQ-017 wr_ptr_gray SHALL pass through SYNC_STAGES flops on rd_clk; last stage = wr_sync; wr_sync converted Gray-to-binary = wr_bin.
REQ-018 Binary read pointer rd_bin (ADDR_WIDTH+1) SHALL advance by 1 per mem_rd_en, wrapping 2^(ADDR_WIDTH+1)-1 -> 0; rd_ptr_gray SHALL be registered bin2gray(rd_bin_next), never combinational.
REQ-019 Internal ptr_empty_next SHALL be (bin2gray(rd_bin_next) == wr_sync).
REQ-020 FWFT=0: mem_rd_en = rd_en & !empty; empty <= ptr_empty_next; rd_valid = 0.
REQ-021 FWFT=1: two-state FSM IDLE (rd_valid=0) / VALID (rd_valid=1); empty = !rd_valid.
REQ-022 FWFT IDLE: if !ptr_empty, mem_rd_en=1, next VALID; else stay IDLE.
REQ-023 FWFT VALID: rd_en & !ptr_empty -> mem_rd_en=1, stay VALID; rd_en & ptr_empty -> IDLE; !rd_en -> stay VALID, mem_rd_en=0.
REQ-024 FWFT requires 1-cycle-latency memory holding output while mem_rd_en=0.
REQ-025 rd_level SHALL be registered (wr_bin - rd_bin_next) mod 2^(ADDR_WIDTH+1), plus 1 when FWFT=1 and next state VALID.
REQ-026 almost_empty SHALL be registered (level_next <= AE_LEVEL).
REQ-027 underflow SHALL pulse 1 the cycle after rd_en=1 with empty=1 (FWFT: rd_valid=0); rejected read SHALL not move any pointer.
REQ-028 Simultaneous pointer change and read SHALL use same-cycle wr_sync; empty may deassert late (pessimistic), never early.

Reset
REQ-029 rd_rstn low SHALL immediately clear sync flops, rd_bin, rd_ptr_gray, rd_level, underflow, rd_valid to 0, set empty=1, almost_empty=1, FSM IDLE; applies mid-operation.
REQ-030 First post-reset update SHALL be on the first rd_clk edge after rd_rstn deasserts.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, AE_LEVEL=1)
REQ-031 Reset: rd_rstn=0 -> empty=1, almost_empty=1, rd_ptr_gray=0000, rd_level=0, rd_valid=0.
REQ-032 FWFT=0: wr_ptr_gray=0010 (bin 3) held -> empty=0, rd_level=3 within 3 clocks; 3 rd_en cycles -> rd_addr 0,1,2, mem_rd_en each cycle, then empty=1, almost_empty=1, rd_ptr_gray=0010.
REQ-033 Underflow: rd_en=1 while empty=1 -> underflow=1 one cycle, rd_addr and rd_ptr_gray unchanged, mem_rd_en=0.
REQ-034 Wrap: 16 reads with writer ahead -> rd_ptr_gray 1000 (bin 15) -> 0000, rd_addr 7 -> 0, no spurious empty.
REQ-035 FWFT=1: wr_ptr_gray=0001 -> mem_rd_en one cycle, rd_valid=1 and empty=0 next cycle; rd_en=1 -> rd_valid=0, empty=1, rd_level=0.
REQ-036 Reset mid-stream (rd_level=5, VALID) -> all outputs to REQ-029 values without clock edge.
